instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes decoded micro-op fields (instruction class, funct, register indices, immediate) into 32-bit RV32I instruction words and writes them sequentially into instruction memory. It is the inverse of the ID-stage control decoder. Testbenches and the boot loader use it to build programs for the pipelined CPU without hand-assembled hex. It is a two-stage valid/ready pipeline with memory-side backpressure, a write-address counter and sticky error reporting.

## Interface
- ADDR_W, 10: word-address width; byte address space is 2^(ADDR_W+2)
- BASE_ADDR, 32'h0: byte address of the first write after reset or start
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  synchronous restart: flush pipeline, clear pointer, count and errors
- valid_i  in  1  micro-op valid
- ready_o  out  1  micro-op accepted on a cycle where valid_i && ready_o
- class_i  in  3  0=R, 1=I-ALU, 2=LW, 3=SW, 4=BEQ; 5-7 illegal
- funct3_i  in  3  used by R and I-ALU only
- funct7_i  in  7  used by R only
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- imm_i  in  13  signed immediate; for BEQ this is the byte offset
- mem_we_o  out  1  write request
- mem_addr_o  out  32  byte address
- mem_data_o  out  32  encoded instruction word
- mem_ready_i  in  1  write completes on a cycle where mem_we_o && mem_ready_i
- count_o  out  16  committed writes, saturating at 16'hFFFF
- err_o  out  1  sticky error flag
- err_code_o  out  2  code of the first error: 1=illegal class, 2=imm out of 12-bit range, 3=BEQ offset odd

## Operation
- **Stage S1 (check)** registers the accepted fields and classifies them.
  - class_i of 5-7 → illegal-class error.
  - I-ALU, LW or SW with imm_i[12]!=imm_i[11] → immediate-range error.
  - BEQ with imm_i[0]=1 → odd-offset error.
  - An errored op is dropped in S1 and never reaches S2.
- **Stage S2 (emit)** holds the encoded word and drives mem_we_o until the write commits. Encodings:
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}
  - I-ALU: {imm[11:0], rs1, funct3, rd, 0010011}
  - LW: {imm[11:0], rs1, 010, rd, 0000011}
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}
- Fields an encoding does not use are ignored.
- **Flow control:** S1 advances when S2 is empty or S2 commits in the same cycle. ready_o = !start_i && (!s1_valid || s1_advances).
- **Address pointer:** mem_addr_o = BASE_ADDR + 4·ptr. ptr increments on each commit and wraps modulo 2^ADDR_W. count_o increments on each commit.
- **Error reporting:** err_o sets on the first error and stays set. err_code_o latches the first code; later errors do not overwrite it.
- **start_i:** clears S1 and S2, ptr, count_o, err_o and err_code_o. It wins over a same-cycle valid_i; nothing is accepted that cycle. If a write is pending, mem_we_o drops and no commit is counted, even if mem_ready_i=1.

## Timing
- Reset values: ready_o=1, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0, count_o=0, err_o=0, err_code_o=0.
- All outputs are registered, except ready_o, which is combinational from the stage-valid flags, mem_ready_i and start_i.
- Latency: an op accepted at clock edge N drives mem_we_o with its word in the cycle after edge N+1, i.e. 2 cycles.
- Throughput is 1 word/cycle while mem_ready_i=1.
- With mem_ready_i held low, at most 2 ops are buffered (one in S1, one in S2). ready_o then stays low until S2 commits.
- mem_addr_o and mem_data_o stay stable while mem_we_o=1 and mem_ready_i=0.
- Asserting rst_i mid-stream clears all state immediately. Buffered ops are discarded.
- Pointer wrap: a commit at ptr=2^ADDR_W-1 makes the next address BASE_ADDR.

## Structure
- A shared package holds:
  - the class codes;
  - the opcode constants (0110011, 0010011, 0000011, 0100011, 1100011), identical to those used by the control decoder;
  - the error codes.
- One sub-module is natural: instr_pack, purely combinational, mapping fields to the 32-bit word and the error code. S1 and S2 use it; the top holds the pipeline registers, pointer and counters.

## Test plan
- add x3,x1,x2 (class 0, f7=0, f3=0, rd=3, rs1=1, rs2=2) → mem_data_o=32'h002081B3 at address 0, 2 cycles after accept; count_o=1.
- lw x5,8(x2), then sw x5,-4(x2), then beq x1,x2,-8, back-to-back with mem_ready_i=1 → words 32'h00812283, 32'hFE512E23, 32'hFE208CE3 at addresses 0, 4, 8 on consecutive cycles.
- Hold mem_ready_i=0 for 4 cycles while offering 3 ops → two are accepted and ready_o drops. After release, all three are written in order with no duplicates; the held address and data never change mid-stall.
- addi with imm_i=2048, then class 7 → err_o=1, err_code_o=2 (not 1), no writes, address and count unchanged.
- ADDR_W=2: 5 commits → addresses 0, 4, 8, 12, 0.
- Pulse start_i during a stall with one op pending → mem_we_o=0 next cycle, count_o=0, err_o=0, next write at BASE_ADDR. Repeat the same scenario using rst_i instead of start_i.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: class codes, RV32I opcodes, error codes and the micro-op record shared by the encoder.
package instr_encoder_pkg;
  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4
  } cls_e;
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CLASS = 2'd1,
    ERR_IMM   = 2'd2,
    ERR_ODD   = 2'd3
  } err_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } uop_t;
endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: maps one micro-op to its RV32I word and classifies it as legal or erroneous.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  uop_t        uop_i,
  output logic [31:0] word_o,
  output err_e        err_o
);
  logic [12:0] m;
  always_comb begin
    m = uop_i.imm;
    case (uop_i.cls)
      CLS_R:   word_o = {uop_i.funct7, uop_i.rs2, uop_i.rs1, uop_i.funct3, uop_i.rd, OP_R};
      CLS_I:   word_o = {m[11:0], uop_i.rs1, uop_i.funct3, uop_i.rd, OP_IMM};
      CLS_LW:  word_o = {m[11:0], uop_i.rs1, 3'b010, uop_i.rd, OP_LOAD};
      CLS_SW:  word_o = {m[11:5], uop_i.rs2, uop_i.rs1, 3'b010, m[4:0], OP_STORE};
      CLS_BEQ: word_o = {m[12], m[10:5], uop_i.rs2, uop_i.rs1, 3'b000, m[4:1], m[11], OP_BRANCH};
      default: word_o = '0;
    endcase
    // a 13-bit immediate fits in 12 bits only when its top two bits agree
    err_o = uop_i.cls > 3'd4 ? ERR_CLASS :
            ((uop_i.cls == CLS_I || uop_i.cls == CLS_LW || uop_i.cls == CLS_SW) && m[12] != m[11]) ? ERR_IMM :
            (uop_i.cls == CLS_BEQ && m[0]) ? ERR_ODD : ERR_NONE;
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage check/emit pipeline writing encoded RV32I words to sequential memory addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  class_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ready_i,
  output logic [15:0] count_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  uop_t              s1_uop_q, s1_uop_d;
  logic [31:0]       s2_data_q, s2_data_d, s1_word;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;
  err_e              err_code_q, err_code_d, s1_err;
  logic              commit, s1_adv, accept, drop, load;
  instr_pack u_pack (
    .uop_i  (s1_uop_q),
    .word_o (s1_word),
    .err_o  (s1_err)
  );
  always_comb begin
    commit     = s2_valid_q && mem_ready_i && !start_i;
    s1_adv     = s1_valid_q && (!s2_valid_q || commit);
    ready_o    = !start_i && (!s1_valid_q || s1_adv);
    accept     = valid_i && ready_o;
    drop       = !start_i && s1_adv && s1_err != ERR_NONE;
    load       = !start_i && s1_adv && s1_err == ERR_NONE;
    s1_valid_d = start_i ? 1'b0 : accept ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
    s1_uop_d   = accept ? {class_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i} : s1_uop_q;
    s2_valid_d = start_i ? 1'b0 : load ? 1'b1 : commit ? 1'b0 : s2_valid_q;
    s2_data_d  = load ? s1_word : s2_data_q;
    ptr_d      = start_i ? '0 : commit ? ptr_q + ADDR_W'(1) : ptr_q;
    count_d    = start_i ? '0 : (commit && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
    err_d      = start_i ? 1'b0 : err_q || drop;
    // only the first error since reset/start is recorded
    err_code_d = start_i ? ERR_NONE : (drop && !err_q) ? s1_err : err_code_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid_q <= 1'b0;
      s1_uop_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_uop_q   <= s1_uop_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end
  assign mem_we_o   = s2_valid_q;
  assign mem_data_o = s2_data_q;
  assign mem_addr_o = BASE_ADDR + 32'({ptr_q, 2'b00});
  assign count_o    = count_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a queue-based reference model.
module tb_instr_encoder;
  logic        clk_i = 0, rst_i = 0, start_i = 0, valid_i = 0, mem_ready_i = 0;
  logic [2:0]  class_i = 0, funct3_i = 0;
  logic [6:0]  funct7_i = 0;
  logic [4:0]  rd_i = 0, rs1_i = 0, rs2_i = 0;
  logic [12:0] imm_i = 0;
  logic        a_ready, a_we, a_err, b_ready, b_we, b_err;
  logic [31:0] a_addr, a_data, b_addr, b_data;
  logic [15:0] a_count, b_count;
  logic [1:0]  a_code, b_code;
  int          checks = 0, failures = 0, n = 0;
  logic [31:0] q[$];
  logic [1:0]  merr = 0;

  instr_encoder u_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .ready_o(a_ready),
    .class_i(class_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .imm_i(imm_i), .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_data_o(a_data),
    .mem_ready_i(mem_ready_i), .count_o(a_count), .err_o(a_err), .err_code_o(a_code)
  );
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(32'h100)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .ready_o(b_ready),
    .class_i(class_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .imm_i(imm_i), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_data_o(b_data),
    .mem_ready_i(mem_ready_i), .count_o(b_count), .err_o(b_err), .err_code_o(b_code)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_err(input int c, input logic [12:0] imm);
    int s = int'($signed(imm));
    if (c > 4) return 2'd1;
    if ((c >= 1 && c <= 3) && (s < -2048 || s > 2047)) return 2'd2;
    if (c == 4 && (s % 2) != 0) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_word(input int c, input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [4:0] rd, rs1, rs2, input logic [12:0] imm);
    logic [31:0] i = 32'(int'($signed(imm)));
    case (c)
      0: return {f7, rs2, rs1, f3, rd, 7'b0110011};
      1: return {i[11:0], rs1, f3, rd, 7'b0010011};
      2: return {i[11:0], rs1, 3'b010, rd, 7'b0000011};
      3: return {i[11:5], rs2, rs1, 3'b010, i[4:0], 7'b0100011};
      default: return {i[12], i[10:5], rs2, rs1, 3'b000, i[4:1], i[11], 7'b1100011};
    endcase
  endfunction

  task automatic clear_model();
    q.delete();
    n = 0;
    merr = 0;
  endtask

  // samples the handshake just before the edge, advances the model, then checks the counters
  task automatic tick();
    logic acc, com;
    logic [1:0] e;
    #2;
    acc = valid_i && a_ready;
    com = a_we && mem_ready_i && !start_i;
    if (a_we && !start_i) begin
      if (q.size() == 0) chk("spurious_we", 32'(a_we), 32'd0);
      else begin
        chk("data", a_data, q[0]);
        chk("addr", a_addr, 32'(n % 1024) * 4);
        chk("data_w2", b_data, q[0]);
        chk("addr_w2", b_addr, 32'h100 + 32'(n % 4) * 4);
      end
    end
    if (start_i) clear_model();
    else begin
      if (com) begin
        void'(q.pop_front());
        n++;
      end
      if (acc) begin
        e = ref_err(int'(class_i), imm_i);
        if (e != 0) begin
          if (merr == 0) merr = e;
        end else q.push_back(ref_word(int'(class_i), funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i));
      end
    end
    @(posedge clk_i);
    #1;
    chk("count", 32'(a_count), 32'(n));
    chk("count_w2", 32'(b_count), 32'(n));
  endtask

  task automatic op(input int c, f3, f7, rd, rs1, rs2, imm);
    valid_i  = 1;
    class_i  = 3'(c);
    funct3_i = 3'(f3);
    funct7_i = 7'(f7);
    rd_i     = 5'(rd);
    rs1_i    = 5'(rs1);
    rs2_i    = 5'(rs2);
    imm_i    = 13'(imm);
  endtask

  task automatic do_start();
    valid_i = 0;
    start_i = 1;
    tick();
    start_i = 0;
  endtask

  task automatic stall_with_pending();
    mem_ready_i = 0;
    op(5, 0, 0, 0, 0, 0, 0);
    tick();
    op(0, 0, 0, 7, 6, 5, 0);
    tick();
    valid_i = 0;
    tick();
    tick();
    chk("pend_we", 32'(a_we), 32'd1);
    chk("pend_err", 32'(a_err), 32'd1);
  endtask

  task automatic write_after_clear(input string tag);
    mem_ready_i = 1;
    op(0, 0, 0, 3, 1, 2, 0);
    tick();
    valid_i = 0;
    tick();
    chk({tag, "_we"}, 32'(a_we), 32'd1);
    chk({tag, "_addr"}, a_addr, 32'h0);
    chk({tag, "_addr_w2"}, b_addr, 32'h100);
    tick();
    chk({tag, "_cnt"}, 32'(a_count), 32'd1);
  endtask

  initial begin
    logic signed [11:0] t;
    int r;
    tick();
    tick();
    rst_i = 1;
    #1;
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_addr_w2", b_addr, 32'h100);
    chk("rst_data", a_data, 32'h0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_code", 32'(a_code), 32'd0);

    // add x3,x1,x2
    do_start();
    mem_ready_i = 1;
    op(0, 0, 0, 3, 1, 2, 0);
    tick();
    valid_i = 0;
    tick();
    chk("add_we", 32'(a_we), 32'd1);
    chk("add_data", a_data, 32'h002081B3);
    chk("add_addr", a_addr, 32'h0);
    tick();
    chk("add_cnt", 32'(a_count), 32'd1);
    chk("add_we_off", 32'(a_we), 32'd0);

    // lw / sw / beq back to back
    do_start();
    op(2, 0, 0, 5, 2, 0, 8);
    tick();
    op(3, 0, 0, 0, 2, 5, -4);
    tick();
    chk("lw_data", a_data, 32'h00812283);
    chk("lw_addr", a_addr, 32'h0);
    op(4, 0, 0, 0, 1, 2, -8);
    tick();
    valid_i = 0;
    chk("sw_data", a_data, 32'hFE512E23);
    chk("sw_addr", a_addr, 32'h4);
    tick();
    chk("beq_data", a_data, 32'hFE208CE3);
    chk("beq_addr", a_addr, 32'h8);
    tick();
    chk("seq_cnt", 32'(a_count), 32'd3);

    // backpressure: two buffered, third held off
    do_start();
    mem_ready_i = 0;
    op(1, 0, 0, 1, 0, 0, 5);
    tick();
    op(0, 0, 32, 2, 1, 1, 0);
    tick();
    op(2, 0, 0, 4, 2, 0, 12);
    #1;
    chk("stall_ready", 32'(a_ready), 32'd0);
    tick();
    tick();
    chk("stall_data", a_data, 32'h00500093);
    chk("stall_addr", a_addr, 32'h0);
    chk("stall_ready2", 32'(a_ready), 32'd0);
    mem_ready_i = 1;
    #1;
    chk("release_ready", 32'(a_ready), 32'd1);
    tick();
    valid_i = 0;
    repeat (4) tick();
    chk("stall_cnt", 32'(a_count), 32'd3);
    chk("stall_drained", 32'(q.size()), 32'd0);

    // errors: range first, then illegal class
    do_start();
    op(1, 0, 0, 1, 1, 0, 2048);
    tick();
    op(7, 0, 0, 0, 0, 0, 0);
    tick();
    valid_i = 0;
    repeat (3) tick();
    chk("err_flag", 32'(a_err), 32'd1);
    chk("err_code", 32'(a_code), 32'd2);
    chk("err_model", 32'(a_code), 32'(merr));
    chk("err_addr", a_addr, 32'h0);
    chk("err_we", 32'(a_we), 32'd0);

    // pointer wrap on the 2-bit instance
    do_start();
    for (int i = 0; i < 5; i++) begin
      op(0, i, 0, i + 1, i, i, 0);
      tick();
    end
    valid_i = 0;
    repeat (3) tick();
    chk("wrap_addr_w2", b_addr, 32'h104);
    chk("wrap_addr", a_addr, 32'd20);

    // start during a stall
    do_start();
    stall_with_pending();
    start_i = 1;
    mem_ready_i = 1;
    tick();
    start_i = 0;
    chk("start_we", 32'(a_we), 32'd0);
    chk("start_err", 32'(a_err), 32'd0);
    chk("start_code", 32'(a_code), 32'd0);
    write_after_clear("start");

    // reset during a stall
    do_start();
    stall_with_pending();
    #2;
    rst_i = 0;
    #1;
    clear_model();
    chk("arst_we", 32'(a_we), 32'd0);
    chk("arst_cnt", 32'(a_count), 32'd0);
    chk("arst_err", 32'(a_err), 32'd0);
    chk("arst_data", a_data, 32'h0);
    rst_i = 1;
    write_after_clear("arst");

    // randomized traffic
    do_start();
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 19));
      t = 12'($urandom);
      valid_i     = $urandom_range(0, 9) < 7;
      start_i     = $urandom_range(0, 99) == 0;
      mem_ready_i = $urandom_range(0, 9) < 7;
      class_i     = r < 18 ? 3'(r % 5) : 3'(5 + $urandom_range(0, 2));
      funct3_i    = 3'($urandom);
      funct7_i    = 7'($urandom);
      rd_i        = 5'($urandom);
      rs1_i       = 5'($urandom);
      rs2_i       = 5'($urandom);
      imm_i       = $urandom_range(0, 9) == 0 ? 13'($urandom) : {t[11], t};
      if (class_i == 3'd4 && $urandom_range(0, 9) != 0) imm_i[0] = 1'b0;
      tick();
    end
    valid_i = 0;
    start_i = 0;
    mem_ready_i = 1;
    repeat (5) tick();
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk("rand_err", 32'(a_err), 32'(merr != 0));
    chk("rand_code", 32'(a_code), 32'(merr));
    chk("rand_we", 32'(a_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
